// File: rtl/lsb_mem_unit.sv
// lsb_mem_unit
// ------------
// Memory-access engine behind the load/store buffer. Takes one load or store
// at a time, walks it over a byte-wide memory port (little-endian, any
// alignment, 32-bit address wrap) and emits a single-cycle (ROB id, value)
// broadcast on the LSB result bus. ROB id 0 on the bus means "idle".
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               mispredict flush; aborts loads, stores run to completion
//   req_valid/ready     request handshake (ready only while idle)
//   req_is_store        1 = store, 0 = load
//   req_width           00 byte, 01 half, 1x word
//   req_signed          sign-extend load result
//   req_addr/data/dest  byte address, store data, ROB id (nonzero)
//   mem_din             read byte, valid the cycle after its address
//   mem_a/dout/wr       memory address, write byte, write strobe
//   dest_to_lsb_bus     result ROB id (0 = no broadcast)
//   value_to_lsb_bus    result value (load data, or 0 for a store)
module lsb_mem_unit #(
    parameter int ROB_ID_WIDTH = 4,
    parameter int XLEN         = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_is_store,
    input  logic [1:0]              req_width,
    input  logic                    req_signed,
    input  logic [31:0]             req_addr,
    input  logic [XLEN-1:0]         req_data,
    input  logic [ROB_ID_WIDTH-1:0] req_dest,
    input  logic [7:0]              mem_din,
    output logic [31:0]             mem_a,
    output logic [7:0]              mem_dout,
    output logic                    mem_wr,
    output logic [ROB_ID_WIDTH-1:0] dest_to_lsb_bus,
    output logic [XLEN-1:0]         value_to_lsb_bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_STORE,
        S_RESULT
    } state_t;

    state_t                  state_reg, state_next;
    logic [2:0]              cnt_reg, cnt_next;
    logic [31:0]             addr_reg;
    logic [31:0]             data_reg;
    logic [ROB_ID_WIDTH-1:0] dest_reg;
    logic                    store_reg;
    logic [1:0]              width_reg;
    logic                    signed_reg;

    logic                    latch;      // handshake this cycle
    logic                    cap_en;     // capture mem_din into a load byte lane
    logic [1:0]              cap_idx;
    logic [2:0]              last_idx;   // index of the final byte (n-1)

    logic [7:0]              load_byte_reg [4];
    logic [7:0]              store_byte    [4];
    logic [31:0]             load_word;
    logic [XLEN-1:0]         load_value;

    // Byte count minus one; width 11 behaves as a word.
    always_comb begin
        case (width_reg)
            2'b00:   last_idx = 3'd0;
            2'b01:   last_idx = 3'd1;
            default: last_idx = 3'd3;
        endcase
    end

    // One register per byte lane of the load buffer; each lane also exposes
    // its slice of the store data for the write path.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign store_byte[gi] = data_reg[8*gi +: 8];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    load_byte_reg[gi] <= 8'h00;
                end else if (latch) begin
                    load_byte_reg[gi] <= 8'h00;
                end else if (cap_en && (cap_idx == 2'(gi))) begin
                    load_byte_reg[gi] <= mem_din;
                end
            end
        end
    endgenerate

    assign load_word = {load_byte_reg[3], load_byte_reg[2], load_byte_reg[1], load_byte_reg[0]};

    // Size casts of signed operands sign-extend, of unsigned ones zero-extend.
    always_comb begin
        case (width_reg)
            2'b00:   load_value = signed_reg ? XLEN'($signed(load_word[7:0]))
                                             : XLEN'(load_word[7:0]);
            2'b01:   load_value = signed_reg ? XLEN'($signed(load_word[15:0]))
                                             : XLEN'(load_word[15:0]);
            default: load_value = XLEN'(load_word);
        endcase
    end

    // State and request registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= S_IDLE;
            cnt_reg    <= 3'd0;
            addr_reg   <= 32'd0;
            data_reg   <= 32'd0;
            dest_reg   <= '0;
            store_reg  <= 1'b0;
            width_reg  <= 2'b00;
            signed_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (latch) begin
                addr_reg   <= req_addr;
                data_reg   <= req_data[31:0];
                dest_reg   <= req_dest;
                store_reg  <= req_is_store;
                width_reg  <= req_width;
                signed_reg <= req_signed;
            end
        end
    end

    // Next state and outputs.
    always_comb begin
        state_next       = state_reg;
        cnt_next         = cnt_reg;
        latch            = 1'b0;
        cap_en           = 1'b0;
        cap_idx          = 2'd0;
        req_ready        = 1'b0;
        mem_a            = 32'd0;
        mem_dout         = 8'h00;
        mem_wr           = 1'b0;
        dest_to_lsb_bus  = '0;
        value_to_lsb_bus = '0;

        case (state_reg)
            S_IDLE: begin
                // rst_n is folded in so ready drops the instant reset asserts.
                req_ready = rst_n & ~flush;
                if (req_valid && req_ready) begin
                    latch      = 1'b1;
                    cnt_next   = 3'd0;
                    state_next = req_is_store ? S_STORE : S_LOAD;
                end
            end

            S_LOAD: begin
                mem_a    = addr_reg + 32'(cnt_reg);
                cnt_next = cnt_reg + 3'd1;
                // Data for the previous address arrives this cycle.
                if (cnt_reg != 3'd0) begin
                    cap_en  = 1'b1;
                    cap_idx = cnt_reg[1:0] - 2'd1;
                end
                if (flush) begin
                    state_next = S_IDLE;
                end else if (cnt_reg == last_idx) begin
                    state_next = S_WAIT;
                end
            end

            S_WAIT: begin
                cap_en     = 1'b1;
                cap_idx    = last_idx[1:0];
                state_next = flush ? S_IDLE : S_RESULT;
            end

            S_STORE: begin
                // Stores are already committed, so flush is ignored here.
                mem_a    = addr_reg + 32'(cnt_reg);
                mem_dout = store_byte[cnt_reg[1:0]];
                mem_wr   = 1'b1;
                cnt_next = cnt_reg + 3'd1;
                if (cnt_reg == last_idx) begin
                    state_next = S_RESULT;
                end
            end

            S_RESULT: begin
                dest_to_lsb_bus  = (flush && !store_reg) ? '0 : dest_reg;
                value_to_lsb_bus = store_reg ? '0 : load_value;
                state_next       = S_IDLE;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_lsb_mem_unit.sv
module tb_lsb_mem_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [1:0]  req_width;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [3:0]  req_dest;
    logic [7:0]  mem_din;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic [3:0]  dest_to_lsb_bus;
    logic [31:0] value_to_lsb_bus;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    lsb_mem_unit #(.ROB_ID_WIDTH(4), .XLEN(32)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .flush            (flush),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_is_store     (req_is_store),
        .req_width        (req_width),
        .req_signed       (req_signed),
        .req_addr         (req_addr),
        .req_data         (req_data),
        .req_dest         (req_dest),
        .mem_din          (mem_din),
        .mem_a            (mem_a),
        .mem_dout         (mem_dout),
        .mem_wr           (mem_wr),
        .dest_to_lsb_bus  (dest_to_lsb_bus),
        .value_to_lsb_bus (value_to_lsb_bus)
    );

    // Byte memory seen by the DUT (indexed by the low address byte) and the
    // reference copy the model maintains independently.
    logic [7:0] mem     [0:255];
    logic [7:0] ref_mem [0:255];
    logic       pre_en = 1'b0;
    logic [7:0] pre_a  = 8'h00;
    logic [7:0] pre_d  = 8'h00;

    always @(posedge clk) begin
        if (pre_en)      mem[pre_a] <= pre_d;
        else if (mem_wr) mem[mem_a[7:0]] <= mem_dout;
        mem_din <= mem[mem_a[7:0]];
    end

    task automatic poke(input logic [31:0] a, input logic [7:0] d);
        @(negedge clk);
        pre_en = 1'b1;
        pre_a  = a[7:0];
        pre_d  = d;
        ref_mem[a[7:0]] = d;
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    function automatic int nbytes(input logic [1:0] w);
        return (w == 2'b00) ? 1 : (w == 2'b01) ? 2 : 4;
    endfunction

    // Reference load: little-endian assembly then arithmetic sign extension.
    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] w, input bit sg);
        int          n = nbytes(w);
        longint      v = 0;
        logic [31:0] ak;
        for (int k = 0; k < n; k++) begin
            ak = a + 32'(k);
            v  = v + (longint'(ref_mem[ak[7:0]]) << (8 * k));
        end
        if (sg && n < 4 && v >= (longint'(1) << (8 * n - 1)))
            v = v - (longint'(1) << (8 * n));
        return 32'(v);
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [1:0] w, input logic [31:0] d);
        logic [31:0] ak;
        for (int k = 0; k < nbytes(w); k++) begin
            ak = a + 32'(k);
            ref_mem[ak[7:0]] = 8'((d >> (8 * k)) & 32'hFF);
        end
    endtask

    // One transaction: handshake, then watch 12 cycles. flush_at = cycle
    // (relative to the handshake) in which flush is held high, or -1.
    task automatic run_op(input string name, input bit st, input logic [1:0] w, input bit sg,
                          input logic [31:0] a, input logic [31:0] d, input logic [3:0] dst,
                          input int flush_at);
        int          n = nbytes(w);
        int          exp_bc, exp_rdy, last_acc, bc_cyc, bc_cnt;
        logic [31:0] exp_val, bc_val, ak;
        logic [3:0]  bc_dest;
        bit          acc_ok, rdy_ok, mem_ok;

        exp_val  = st ? 32'd0 : model_load(a, w, sg);
        exp_bc   = st ? n + 1 : n + 2;
        exp_rdy  = exp_bc + 1;
        last_acc = n;
        if (!st && flush_at >= 1 && flush_at <= n + 2) begin
            exp_bc   = -1;
            exp_rdy  = ((flush_at < n + 2) ? flush_at : n + 2) + 1;
            last_acc = (flush_at < n) ? flush_at : n;
        end
        if (st) model_store(a, w, d);

        @(negedge clk);
        req_valid    = 1'b1;
        req_is_store = st;
        req_width    = w;
        req_signed   = sg;
        req_addr     = a;
        req_data     = d;
        req_dest     = dst;
        flush        = 1'b0;
        #1;
        tests_run++;
        if (req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s_accept: req_ready=%b required 1", name, req_ready);
        end
        @(posedge clk);

        acc_ok = 1'b1; rdy_ok = 1'b1;
        bc_cyc = -1; bc_cnt = 0; bc_dest = 4'd0; bc_val = 32'd0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            req_data  = $urandom;
            req_addr  = $urandom;
            flush     = (c == flush_at);
            #1;
            if (c <= last_acc) begin
                ak = a + 32'(c - 1);
                if (mem_a !== ak || mem_wr !== st ||
                    mem_dout !== (st ? 8'((d >> (8 * (c - 1))) & 32'hFF) : 8'h00))
                    acc_ok = 1'b0;
            end else if (mem_wr !== 1'b0 || mem_a !== 32'd0 || mem_dout !== 8'h00) begin
                acc_ok = 1'b0;
            end
            if (req_ready !== (c >= exp_rdy)) rdy_ok = 1'b0;
            if (dest_to_lsb_bus !== 4'd0) begin
                bc_cnt++;
                if (bc_cyc < 0) begin
                    bc_cyc  = c;
                    bc_dest = dest_to_lsb_bus;
                    bc_val  = value_to_lsb_bus;
                end
            end
        end
        flush = 1'b0;

        $display("[TB] %s st=%0d w=%0d sg=%0d addr=%h data=%h dest=%0d flush_at=%0d -> bc_cyc=%0d dest=%0d value=%h",
                 name, st, w, sg, a, d, dst, flush_at, bc_cyc, bc_dest, bc_val);

        tests_run++;
        if (!acc_ok) begin
            tests_failed++;
            $display("FAIL %s_mem_port: memory port sequence wrong (last mem_a=%h) required %0d accesses from %h",
                     name, mem_a, last_acc, a);
        end
        tests_run++;
        if (!rdy_ok) begin
            tests_failed++;
            $display("FAIL %s_ready: req_ready timing wrong, required high from cycle %0d", name, exp_rdy);
        end
        tests_run++;
        if (bc_cyc !== exp_bc || bc_cnt !== ((exp_bc > 0) ? 1 : 0)) begin
            tests_failed++;
            $display("FAIL %s_bcast_cycle: broadcast cycle=%0d count=%0d required cycle=%0d",
                     name, bc_cyc, bc_cnt, exp_bc);
        end
        if (exp_bc > 0) begin
            tests_run++;
            if (bc_dest !== dst || bc_val !== exp_val) begin
                tests_failed++;
                $display("FAIL %s_result: dest=%0d value=%h required dest=%0d value=%h",
                         name, bc_dest, bc_val, dst, exp_val);
            end
        end
        if (st) begin
            mem_ok = 1'b1;
            for (int k = -1; k <= 4; k++) begin
                ak = a + 32'(k);
                if (mem[ak[7:0]] !== ref_mem[ak[7:0]]) mem_ok = 1'b0;
            end
            tests_run++;
            if (!mem_ok) begin
                tests_failed++;
                $display("FAIL %s_mem_contents: bytes around %h differ from required store result", name, a);
            end
        end
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        flush        = 1'b0;
        req_valid    = 1'b1;
        req_is_store = 1'b0;
        req_width    = 2'b10;
        req_signed   = 1'b0;
        req_addr     = 32'h0000_0123;
        req_data     = 32'd0;
        req_dest     = 4'd1;
        #3;
        tests_run++;
        if (req_ready !== 1'b0 || mem_a !== 32'd0 || mem_wr !== 1'b0 || mem_dout !== 8'h00 ||
            dest_to_lsb_bus !== 4'd0 || value_to_lsb_bus !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: ready=%b mem_a=%h wr=%b dout=%h dest=%0d value=%h required all 0",
                     req_ready, mem_a, mem_wr, mem_dout, dest_to_lsb_bus, value_to_lsb_bus);
        end
        @(negedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst_n     = 1'b1;
        #1;
        tests_run++;
        if (req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_release_ready: req_ready=%b required 1", req_ready);
        end
    endtask

    task automatic test_lb();
        poke(32'h0000_0100, 8'h80);
        run_op("lb_signed",   1'b0, 2'b00, 1'b1, 32'h0000_0100, 32'd0, 4'd3, -1);
        run_op("lb_unsigned", 1'b0, 2'b00, 1'b0, 32'h0000_0100, 32'd0, 4'd3, -1);
    endtask

    task automatic test_lw_misaligned();
        poke(32'h0000_0201, 8'h11);
        poke(32'h0000_0202, 8'h22);
        poke(32'h0000_0203, 8'h33);
        poke(32'h0000_0204, 8'h44);
        run_op("lw_misaligned", 1'b0, 2'b10, 1'b0, 32'h0000_0201, 32'd0, 4'd7, -1);
        run_op("lw_width11",    1'b0, 2'b11, 1'b1, 32'h0000_0201, 32'd0, 4'd8, -1);
    endtask

    task automatic test_sh();
        run_op("sh", 1'b1, 2'b01, 1'b0, 32'h0000_0040, 32'hABCD_1234, 4'd5, -1);
    endtask

    task automatic test_flush();
        run_op("lw_flush_t2",   1'b0, 2'b10, 1'b0, 32'h0000_0201, 32'd0, 4'd7, 2);
        run_op("sw_flush_t2",   1'b1, 2'b10, 1'b0, 32'h0000_0060, 32'h5566_7788, 4'd9, 2);
        run_op("lb_flush_res",  1'b0, 2'b00, 1'b1, 32'h0000_0100, 32'd0, 4'd2, 3);
        run_op("lh_flush_wait", 1'b0, 2'b01, 1'b0, 32'h0000_0201, 32'd0, 4'd4, 3);
    endtask

    task automatic test_wrap();
        poke(32'hFFFF_FFFF, 8'h01);
        poke(32'h0000_0000, 8'hFF);
        run_op("lh_wrap", 1'b0, 2'b01, 1'b1, 32'hFFFF_FFFF, 32'd0, 4'd6, -1);
    endtask

    task automatic test_flush_idle();
        @(negedge clk);
        req_valid    = 1'b1;
        req_is_store = 1'b0;
        req_width    = 2'b10;
        req_addr     = 32'h0000_0355;
        req_dest     = 4'd1;
        flush        = 1'b1;
        #1;
        tests_run++;
        if (req_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_idle_ready: req_ready=%b required 0", req_ready);
        end
        @(negedge clk);
        req_valid = 1'b0;
        flush     = 1'b0;
        #1;
        $display("[TB] flush_idle request with flush -> mem_a=%h ready=%b", mem_a, req_ready);
        tests_run++;
        if (mem_a !== 32'd0 || req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_idle_reject: mem_a=%h ready=%b required mem_a=0 ready=1", mem_a, req_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a1 = 32'h0000_0201;
        logic [31:0] a2 = 32'h0000_0040;
        logic [31:0] e1, e2, v1, v2;
        int          bc1 = -1, bc2 = -1, hs2 = -1;
        e1 = model_load(a1, 2'b10, 1'b0);
        e2 = model_load(a2, 2'b10, 1'b0);
        v1 = 32'd0; v2 = 32'd0;
        @(negedge clk);
        req_valid    = 1'b1;
        req_is_store = 1'b0;
        req_width    = 2'b10;
        req_signed   = 1'b0;
        req_addr     = a1;
        req_dest     = 4'd4;
        @(posedge clk);
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (c == 1) begin
                req_addr = a2;
                req_dest = 4'd6;
            end
            if (hs2 >= 0) req_valid = 1'b0;
            #1;
            if (dest_to_lsb_bus == 4'd4 && bc1 < 0) begin bc1 = c; v1 = value_to_lsb_bus; end
            if (dest_to_lsb_bus == 4'd6 && bc2 < 0) begin bc2 = c; v2 = value_to_lsb_bus; end
            if (req_valid && req_ready && hs2 < 0) hs2 = c;
        end
        req_valid = 1'b0;
        $display("[TB] back_to_back lw/lw -> bc1=%0d v1=%h hs2=%0d bc2=%0d v2=%h", bc1, v1, hs2, bc2, v2);
        tests_run++;
        if (bc1 != 6 || hs2 != 7 || bc2 != 13) begin
            tests_failed++;
            $display("FAIL b2b_timing: bc1=%0d hs2=%0d bc2=%0d required 6 7 13", bc1, hs2, bc2);
        end
        tests_run++;
        if (v1 !== e1 || v2 !== e2) begin
            tests_failed++;
            $display("FAIL b2b_values: v1=%h v2=%h required %h %h", v1, v2, e1, e2);
        end
    endtask

    task automatic test_random();
        bit          st, sg;
        logic [1:0]  w;
        logic [31:0] a, d;
        logic [3:0]  dst;
        int          fa, sel;
        for (int i = 0; i < 40; i++) begin
            st  = 1'($urandom_range(0, 1));
            sg  = 1'($urandom_range(0, 1));
            w   = 2'($urandom_range(0, 3));
            d   = $urandom;
            dst = 4'($urandom_range(1, 15));
            sel = $urandom_range(0, 2);
            if (sel == 0)      a = 32'h0000_0300 + 32'($urandom_range(0, 15));
            else if (sel == 1) a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
            else               a = $urandom;
            fa = -1;
            if ($urandom_range(0, 3) == 0)
                fa = $urandom_range(1, st ? nbytes(w) + 1 : nbytes(w) + 2);
            run_op($sformatf("rand%0d", i), st, w, sg, a, d, dst, fa);
        end
    endtask

    task automatic test_async_reset();
        bit quiet = 1'b1;
        @(negedge clk);
        req_valid    = 1'b1;
        req_is_store = 1'b0;
        req_width    = 2'b10;
        req_addr     = 32'h0000_0300;
        req_dest     = 4'd2;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (req_ready !== 1'b0 || mem_a !== 32'd0 || mem_wr !== 1'b0 || mem_dout !== 8'h00 ||
            dest_to_lsb_bus !== 4'd0 || value_to_lsb_bus !== 32'd0) begin
            tests_failed++;
            $display("FAIL async_reset_outputs: ready=%b mem_a=%h dest=%0d required all 0",
                     req_ready, mem_a, dest_to_lsb_bus);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            if (dest_to_lsb_bus !== 4'd0 || req_ready !== 1'b1 || mem_a !== 32'd0) quiet = 1'b0;
        end
        $display("[TB] async_reset mid-lw -> quiet after release=%0d", quiet);
        tests_run++;
        if (!quiet) begin
            tests_failed++;
            $display("FAIL async_reset_no_bcast: activity seen after release, required idle with no broadcast");
        end
    endtask

    initial begin
        test_reset();
        for (int i = 0; i < 256; i++) poke(32'(i), 8'($urandom));
        test_lb();
        test_lw_misaligned();
        test_sh();
        test_flush();
        test_wrap();
        test_flush_idle();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
